// File: rtl/tlc_multi_dir.sv
// Multi-approach traffic light controller: round-robin GREEN -> YELLOW -> ALLRED with demand skipping.
// Optional emergency preemption is enabled by defining EMERG_PREEMPT_EN.
module tlc_multi_dir #(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned DIR_W    = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DIR-1:0] demand,
`ifdef EMERG_PREEMPT_EN
  input  logic               emerg_req,
  input  logic [DIR_W-1:0]   emerg_dir,
`endif
  output logic [1:0]         state,
  output logic [DIR_W-1:0]   dir,
  output logic [CNT_W-1:0]   count,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [DIR_W-1:0] DIR_RST = DIR_W'(NUM_DIR - 1);

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rr_found;
  logic [DIR_W-1:0]   rr_dir;
  int unsigned        rr_best;
  int unsigned        rr_dist;

  logic               run;
  logic               trunc;
  logic               hold;
  logic               pre_exit;
  logic [DIR_W-1:0]   pre_dir;

`ifdef EMERG_PREEMPT_EN
  assign run      = en | emerg_req;
  assign trunc    = emerg_req & (dir_q != emerg_dir);
  assign hold     = emerg_req & (dir_q == emerg_dir);
  assign pre_exit = emerg_req;
  assign pre_dir  = emerg_dir;
`else
  assign run      = en;
  assign trunc    = 1'b0;
  assign hold     = 1'b0;
  assign pre_exit = 1'b0;
  assign pre_dir  = '0;
`endif

  // Nearest demanding approach after dir_q; dir_q itself counts as the farthest (distance NUM_DIR).
  always_comb begin
    rr_found = 1'b0;
    rr_dir   = dir_q;
    rr_best  = NUM_DIR + 1;
    rr_dist  = 0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      rr_dist = (i + NUM_DIR - 32'(dir_q)) % NUM_DIR;
      if (rr_dist == 0) rr_dist = NUM_DIR;
      if (demand[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_dir   = DIR_W'(i);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    count_d = count_q;
    if (run) begin
      unique case (state_q)
        ST_GREEN: begin
          if (trunc) begin
            state_d = ST_YELLOW;
            count_d = '0;
          end else if (count_q == G_LAST) begin
            if (!hold) begin
              state_d = ST_YELLOW;
              count_d = '0;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (count_q == Y_LAST) begin
            state_d = ST_ALLRED;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        ST_ALLRED: begin
          if (count_q == AR_LAST) begin
            if (pre_exit) begin
              state_d = ST_GREEN;
              dir_d   = pre_dir;
              count_d = '0;
            end else if (rr_found) begin
              state_d = ST_GREEN;
              dir_d   = rr_dir;
              count_d = '0;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_ALLRED;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ALLRED;
      dir_q   <= DIR_RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign dir   = dir_q;
  assign count = count_q;

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '1;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (dir_q == DIR_W'(i)) begin
        green[i]  = (state_q == ST_GREEN);
        yellow[i] = (state_q == ST_YELLOW);
        red[i]    = (state_q == ST_ALLRED);
      end
    end
  end

endmodule

// File: tb/tb_tlc_multi_dir.sv
// Self-checking bench for tlc_multi_dir: a 2-approach and a 4-approach instance against a phase-level model.
module tb_tlc_multi_dir;

  localparam int DUR [3] = '{8, 3, 2};

  logic       clk;
  logic       rst_a, en_a, er, er_b;
  logic [1:0] dem_a, ed, ed_b;
  logic       rst_b, en_b;
  logic [3:0] dem_b;

  logic [1:0] st_a, dir_a, g_a, y_a, r_a;
  logic [3:0] cnt_a;
  logic [1:0] st_b, dir_b;
  logic [3:0] cnt_b, g_b, y_b, r_b;

  int n_total = 0;
  int n_pass  = 0;

  int m_ph  [2];
  int m_dir [2];
  int m_el  [2];
  int m_n   [2] = '{2, 4};

  wire [13:0] obs_a = {st_a, dir_a, cnt_a, g_a, y_a, r_a};
  wire [19:0] obs_b = {st_b, dir_b, cnt_b, g_b, y_b, r_b};

  tlc_multi_dir #(.NUM_DIR(2), .DIR_W(2), .CNT_W(4), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .demand(dem_a),
`ifdef EMERG_PREEMPT_EN
    .emerg_req(er), .emerg_dir(ed),
`endif
    .state(st_a), .dir(dir_a), .count(cnt_a), .green(g_a), .yellow(y_a), .red(r_a)
  );

  tlc_multi_dir #(.NUM_DIR(4), .DIR_W(2), .CNT_W(4), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .demand(dem_b),
`ifdef EMERG_PREEMPT_EN
    .emerg_req(er_b), .emerg_dir(ed_b),
`endif
    .state(st_b), .dir(dir_b), .count(cnt_b), .green(g_b), .yellow(y_b), .red(r_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic model_reset(input int u);
    m_ph[u]  = 2;
    m_dir[u] = m_n[u] - 1;
    m_el[u]  = 0;
  endtask

  // One enabled cycle of the controller as described by its phase rules.
  task automatic model_step(input int u, input bit en, input int dem, input bit req, input int edir);
    int i;
    if (!en && !req) return;
    if (m_ph[u] == 0 && req && m_dir[u] != edir) begin
      m_ph[u] = 1; m_el[u] = 0; return;
    end
    if (m_el[u] < DUR[m_ph[u]] - 1) begin
      m_el[u]++; return;
    end
    case (m_ph[u])
      0: begin
        if (!(req && m_dir[u] == edir)) begin m_ph[u] = 1; m_el[u] = 0; end
      end
      1: begin m_ph[u] = 2; m_el[u] = 0; end
      default: begin
        if (req) begin
          m_dir[u] = edir; m_ph[u] = 0; m_el[u] = 0;
        end else begin
          for (int k = 1; k <= m_n[u]; k++) begin
            i = (m_dir[u] + k) % m_n[u];
            if (dem[i]) begin
              m_dir[u] = i; m_ph[u] = 0; m_el[u] = 0;
              break;
            end
          end
        end
      end
    endcase
  endtask

  function automatic logic [13:0] exp_a();
    logic [1:0] on;
    on = 2'(1 << m_dir[0]);
    return {2'(m_ph[0]), 2'(m_dir[0]), 4'(m_el[0]),
            (m_ph[0] == 0) ? on : 2'b00, (m_ph[0] == 1) ? on : 2'b00,
            (m_ph[0] == 2) ? 2'b11 : ~on};
  endfunction

  function automatic logic [19:0] exp_b();
    logic [3:0] on;
    on = 4'(1 << m_dir[1]);
    return {2'(m_ph[1]), 2'(m_dir[1]), 4'(m_el[1]),
            (m_ph[1] == 0) ? on : 4'b0000, (m_ph[1] == 1) ? on : 4'b0000,
            (m_ph[1] == 2) ? 4'b1111 : ~on};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_a) model_reset(0); else model_step(0, en_a, int'(dem_a), er, int'(ed));
    if (!rst_b) model_reset(1); else model_step(1, en_b, int'(dem_b), er_b, int'(ed_b));
    #1;
  endtask

  // Pulse reset between edges; the observation right after release is cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    model_reset(0); model_reset(1);
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_reset();
    en_a = 1'b1; en_b = 1'b1; dem_a = 2'b11; dem_b = 4'b1111;
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    n_total++;
    if (obs_a !== {2'b10, 2'd1, 4'd0, 2'b00, 2'b00, 2'b11})
      $display("FAIL reset_a: got %b want %b", obs_a, {2'b10, 2'd1, 4'd0, 2'b00, 2'b00, 2'b11});
    else n_pass++;
    n_total++;
    if (obs_b !== {2'b10, 2'd3, 4'd0, 4'b0000, 4'b0000, 4'b1111})
      $display("FAIL reset_b: got %b want %b", obs_b, {2'b10, 2'd3, 4'd0, 4'b0000, 4'b0000, 4'b1111});
    else n_pass++;
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_timeline();
    int u, r, es, ed_t, ec;
    en_a = 1'b1; dem_a = 2'b11;
    do_reset();
    for (int t = 0; t <= 26; t++) begin
      if (t < 2) begin
        es = 2; ed_t = 1; ec = t;
      end else begin
        u = t - 2; r = u % 13; ed_t = (u / 13) % 2;
        if (r < 8) begin es = 0; ec = r; end
        else if (r < 11) begin es = 1; ec = r - 8; end
        else begin es = 2; ec = r - 11; end
      end
      n_total++;
      if ({st_a, dir_a, cnt_a} !== {2'(es), 2'(ed_t), 4'(ec)})
        $display("FAIL timeline_c%0d: got st=%b dir=%0d cnt=%0d want st=%0d dir=%0d cnt=%0d",
                 t, st_a, dir_a, cnt_a, es, ed_t, ec);
      else n_pass++;
      n_total++;
      if (((g_a & y_a) !== 2'b00) || ($countones(g_a | y_a) > 1) || ((g_a | y_a | r_a) !== 2'b11))
        $display("FAIL lamps_c%0d: got g=%b y=%b r=%b want exclusive one-hot", t, g_a, y_a, r_a);
      else n_pass++;
      if (t < 26) tick();
    end
  endtask

  task automatic test_skip();
    int starts;
    en_b = 1'b1; dem_b = 4'b0101;
    do_reset();
    starts = 0;
    for (int t = 0; t < 80; t++) begin
      n_total++;
      if (obs_b !== exp_b()) $display("FAIL skip_model_c%0d: got %b want %b", t, obs_b, exp_b());
      else n_pass++;
      n_total++;
      if ((g_b & 4'b1010) !== 4'b0000) $display("FAIL skip_idle_green_c%0d: got g=%b want bits1,3 low", t, g_b);
      else n_pass++;
      if (st_b == 2'b00 && cnt_b == 4'd0) begin
        n_total++;
        if (dir_b !== 2'((starts % 2) * 2))
          $display("FAIL skip_order_%0d: got dir=%0d want %0d", starts, dir_b, (starts % 2) * 2);
        else n_pass++;
        starts++;
      end
      tick();
    end
    n_total++;
    if (starts < 4) $display("FAIL skip_count: got %0d greens want >=4", starts);
    else n_pass++;
  endtask

  task automatic test_idle();
    en_a = 1'b1; dem_a = 2'b00;
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      n_total++;
      if ({st_a, dir_a, cnt_a} !== {2'b10, 2'd1, 4'((t == 0) ? 0 : 1)})
        $display("FAIL idle_c%0d: got st=%b dir=%0d cnt=%0d want st=10 dir=1 cnt=%0d",
                 t, st_a, dir_a, cnt_a, (t == 0) ? 0 : 1);
      else n_pass++;
      if (t < 20) tick();
    end
    dem_a = 2'b10;
    tick();
    n_total++;
    if ({st_a, dir_a, cnt_a, g_a} !== {2'b00, 2'd1, 4'd0, 2'b10})
      $display("FAIL idle_wake: got st=%b dir=%0d cnt=%0d g=%b want st=00 dir=1 cnt=0 g=10",
               st_a, dir_a, cnt_a, g_a);
    else n_pass++;
  endtask

  task automatic test_freeze();
    en_a = 1'b1; dem_a = 2'b11;
    do_reset();
    repeat (5) tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b00, 2'd0, 4'd3})
      $display("FAIL freeze_pre: got st=%b dir=%0d cnt=%0d want st=00 dir=0 cnt=3", st_a, dir_a, cnt_a);
    else n_pass++;
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (obs_a !== {2'b00, 2'd0, 4'd3, 2'b01, 2'b00, 2'b10})
        $display("FAIL freeze_hold_%0d: got %b want %b", k, obs_a, {2'b00, 2'd0, 4'd3, 2'b01, 2'b00, 2'b10});
      else n_pass++;
    end
    en_a = 1'b1;
    tick();
    n_total++;
    if (cnt_a !== 4'd4) $display("FAIL freeze_resume: got cnt=%0d want 4", cnt_a);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if ({st_a, cnt_a} !== {2'b00, 4'd7}) $display("FAIL freeze_c14: got st=%b cnt=%0d want st=00 cnt=7", st_a, cnt_a);
    else n_pass++;
    tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b01, 2'd0, 4'd0})
      $display("FAIL freeze_c15: got st=%b dir=%0d cnt=%0d want st=01 dir=0 cnt=0", st_a, dir_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    en_a = 1'b1; dem_a = 2'b11;
    do_reset();
    repeat (24) tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b01, 2'd1, 4'd1})
      $display("FAIL midrst_pre: got st=%b dir=%0d cnt=%0d want st=01 dir=1 cnt=1", st_a, dir_a, cnt_a);
    else n_pass++;
    rst_a = 1'b0;
    model_reset(0);
    #1;
    n_total++;
    if (obs_a !== {2'b10, 2'd1, 4'd0, 2'b00, 2'b00, 2'b11})
      $display("FAIL midrst_async: got %b want %b", obs_a, {2'b10, 2'd1, 4'd0, 2'b00, 2'b00, 2'b11});
    else n_pass++;
    tick();
    rst_a = 1'b1;
    tick();
    tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b00, 2'd0, 4'd0})
      $display("FAIL midrst_first_green: got st=%b dir=%0d cnt=%0d want st=00 dir=0 cnt=0", st_a, dir_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 500; t++) begin
      en_a  = ($urandom_range(0, 9) < 8);
      en_b  = ($urandom_range(0, 9) < 8);
      dem_a = 2'($urandom);
      dem_b = 4'($urandom);
      tick();
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL rand_a_%0d: got %b want %b", t, obs_a, exp_a());
      else n_pass++;
      n_total++;
      if (obs_b !== exp_b()) $display("FAIL rand_b_%0d: got %b want %b", t, obs_b, exp_b());
      else n_pass++;
    end
  endtask

`ifdef EMERG_PREEMPT_EN
  task automatic test_emerg();
    en_a = 1'b1; dem_a = 2'b11; ed = 2'd1; er = 1'b0;
    do_reset();
    repeat (4) tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b00, 2'd0, 4'd2})
      $display("FAIL emerg_pre: got st=%b dir=%0d cnt=%0d want st=00 dir=0 cnt=2", st_a, dir_a, cnt_a);
    else n_pass++;
    er = 1'b1;
    tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b01, 2'd0, 4'd0})
      $display("FAIL emerg_trunc: got st=%b dir=%0d cnt=%0d want st=01 dir=0 cnt=0", st_a, dir_a, cnt_a);
    else n_pass++;
    for (int t = 0; t < 30; t++) begin
      tick();
      n_total++;
      if (obs_a !== exp_a()) $display("FAIL emerg_model_%0d: got %b want %b", t, obs_a, exp_a());
      else n_pass++;
    end
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b00, 2'd1, 4'd7})
      $display("FAIL emerg_hold: got st=%b dir=%0d cnt=%0d want st=00 dir=1 cnt=7", st_a, dir_a, cnt_a);
    else n_pass++;
    er = 1'b0;
    tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b01, 2'd1, 4'd0})
      $display("FAIL emerg_release: got st=%b dir=%0d cnt=%0d want st=01 dir=1 cnt=0", st_a, dir_a, cnt_a);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if ({st_a, dir_a, cnt_a} !== {2'b00, 2'd0, 4'd0})
      $display("FAIL emerg_resume: got st=%b dir=%0d cnt=%0d want st=00 dir=0 cnt=0", st_a, dir_a, cnt_a);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    dem_a = 2'b11; dem_b = 4'b1111;
    er = 1'b0; ed = 2'd0; er_b = 1'b0; ed_b = 2'd0;
    test_reset();
    test_timeline();
    test_skip();
    test_idle();
    test_freeze();
    test_reset_mid();
    test_random();
`ifdef EMERG_PREEMPT_EN
    test_emerg();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
